// File: rtl/frame_gate_pkg.sv
// frame_gate_pkg: gate FSM state encoding and ctrl_cmd codes shared by frame_gate_ctrl
package frame_gate_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_SOF, ST_PASS, ST_FLUSH, ST_DROP} state_t;
  localparam logic [3:0] CMD_STOP   = 4'b0000;
  localparam logic [3:0] CMD_RUN    = 4'b0001;
  localparam logic [3:0] CMD_SINGLE = 4'b0010;
  localparam logic [3:0] CMD_CLR    = 4'b0011;
endpackage

// File: rtl/frame_gate_ctrl_axis_out_slot.sv
// axis_out_slot: one-entry AXIS output register; ins loads a synthetic beat (data 0, tlast 1, tuser 0)
//   in_*     beat to load when can_load
//   ins      load the synthetic end-of-line beat instead of in_*
//   can_load slot empty or being drained this cycle
//   m_*      AXIS master side, held stable while m_tvalid & !m_tready
module axis_out_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic                  ins,
  output logic                  can_load,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tuser
);
  logic vld_q, vld_d, last_q, last_d, user_q, user_d, ld;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    can_load = !vld_q || m_tready;
    ld       = can_load && (in_valid || ins);
    vld_d    = can_load ? (in_valid || ins) : vld_q;
    data_d   = ld ? (ins ? '0 : in_data) : data_q;
    last_d   = ld ? (ins || in_last) : last_q;
    user_d   = ld ? (!ins && in_user) : user_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      user_q <= user_d;
    end
  assign m_tvalid = vld_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;
  assign m_tuser  = user_q;
endmodule

// File: rtl/frame_gate_ctrl.sv
// frame_gate_ctrl: frame-aligned gate between a non-stallable pixel source and an AXIS FIFO
//   ctrl_cmd      stop / run / single frame / clear stats
//   s_axis_*      source beats (no tready), tlast = end of line, tuser = start of frame
//   m_axis_*      gated output through a one-entry slot
//   busy          in PASS or FLUSH
//   frame_cnt     complete frames passed, drop_cnt frames aborted on overflow (saturating)
//   geom_err      sticky line/frame geometry violation
module frame_gate_ctrl
  import frame_gate_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  input  logic [3:0]            ctrl_cmd,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  geom_err
);
  // x carries one spare bit so an overlong line saturates instead of wrapping back onto IMG_WIDTH-1
  localparam int XW = $clog2(IMG_WIDTH + 1) + 1;
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, x0;
  logic [YW-1:0] y_q, y_d, y0;
  logic [3:0] cmd_q;
  logic single_q, single_d, stop_q, stop_d, fl_q, fl_d, geom_q, geom_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic fwd, ins, ovf, done, gerr, cont, clr, can_load;
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    single_d = single_q;
    stop_d   = stop_q || (ctrl_cmd == CMD_STOP);
    fl_d     = fl_q;
    fwd      = 1'b0;
    ins      = 1'b0;
    ovf      = 1'b0;
    done     = 1'b0;
    gerr     = 1'b0;
    // a SOF beat always restarts geometry at (0,0), whether it opens or re-opens a frame
    x0       = s_axis_tuser ? '0 : x_q;
    y0       = s_axis_tuser ? '0 : y_q;
    cont     = !single_q && !stop_q && (ctrl_cmd != CMD_STOP);
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (ctrl_cmd == CMD_RUN) begin
          state_d  = ST_WAIT_SOF;
          single_d = 1'b0;
        end else if (ctrl_cmd == CMD_SINGLE && cmd_q != CMD_SINGLE) begin
          state_d  = ST_WAIT_SOF;
          single_d = 1'b1;
        end
      end
      ST_WAIT_SOF:
        if (!single_q && ctrl_cmd == CMD_STOP) state_d = ST_IDLE;
        else fwd = s_axis_tvalid && s_axis_tuser && can_load;
      ST_PASS: begin
        fwd  = s_axis_tvalid && can_load;
        ovf  = s_axis_tvalid && !can_load;
        gerr = fwd && s_axis_tuser && (x_q != '0 || y_q != '0);
      end
      ST_FLUSH: begin
        // the synthetic beat enters the slot in the cycle the held beat drains
        ins  = !fl_q && can_load;
        fl_d = fl_q || ins;
        if (fl_q && m_axis_tvalid && m_axis_tready) begin
          state_d = ST_DROP;
          fl_d    = 1'b0;
        end
      end
      ST_DROP:
        if (s_axis_tvalid && s_axis_tuser) begin
          if (cont) fwd = can_load;
          else state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
    if (fwd) begin
      state_d = ST_PASS;
      y_d     = y0;
      if (s_axis_tlast) begin
        x_d  = '0;
        gerr = gerr || (x0 != XMAX);
        done = (y0 == YMAX);
        y_d  = done ? '0 : y0 + 1'b1;
        if (done) state_d = cont ? ST_WAIT_SOF : ST_IDLE;
      end else x_d = (&x0) ? x0 : x0 + 1'b1;
    end
    if (ovf) begin
      state_d = ST_FLUSH;
      x_d     = '0;
      y_d     = '0;
    end
  end
  always_comb begin
    clr         = (ctrl_cmd == CMD_CLR);
    frame_cnt_d = clr ? '0 : (done && !(&frame_cnt_q)) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    drop_cnt_d  = clr ? '0 : (ovf && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    geom_d      = !clr && (geom_q || gerr);
  end
  always_ff @(posedge s_aclk or negedge s_aresetn)
    if (!s_aresetn) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cmd_q       <= CMD_STOP;
      single_q    <= 1'b0;
      stop_q      <= 1'b0;
      fl_q        <= 1'b0;
      geom_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_q       <= ctrl_cmd;
      single_q    <= single_d;
      stop_q      <= stop_d;
      fl_q        <= fl_d;
      geom_q      <= geom_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  axis_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
    .clk      (s_aclk),
    .rst_n    (s_aresetn),
    .in_valid (fwd),
    .in_data  (s_axis_tdata),
    .in_last  (s_axis_tlast),
    .in_user  (s_axis_tuser),
    .ins      (ins),
    .can_load (can_load),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast),
    .m_tuser  (m_axis_tuser)
  );
  assign busy      = (state_q == ST_PASS) || (state_q == ST_FLUSH);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign geom_err  = geom_q;
endmodule

// File: tb/tb_frame_gate_ctrl.sv
// tb_frame_gate_ctrl: scoreboard bench for frame_gate_ctrl with a 4x3 image
module tb_frame_gate_ctrl;
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  logic clk = 1'b0;
  logic s_aresetn, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready;
  logic [3:0] ctrl_cmd;
  logic [7:0] s_axis_tdata, m_axis_tdata, frame_cnt, drop_cnt;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, geom_err;
  beat_t exp_q[$];
  beat_t mon_e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  frame_gate_ctrl #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .CNT_WIDTH(8)) dut (
    .s_aclk(clk), .s_aresetn(s_aresetn), .ctrl_cmd(ctrl_cmd),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .geom_err(geom_err)
  );
  always @(negedge clk)
    if (s_aresetn && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected output d=%h l=%b u=%b", m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== mon_e) begin
          errors++;
          $display("FAIL beat: got d=%h l=%b u=%b expected d=%h l=%b u=%b",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser, mon_e.d, mon_e.l, mon_e.u);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void push(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d;
    b.l = l;
    b.u = u;
    exp_q.push_back(b);
  endfunction
  task automatic drive(input logic [7:0] d, input logic l, input logic u, input logic rdy);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    m_axis_tready = rdy;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      m_axis_tready = 1'b1;
    end
  endtask
  task automatic cmd(input logic [3:0] c);
    @(posedge clk);
    #1;
    ctrl_cmd      = c;
    s_axis_tvalid = 1'b0;
  endtask
  // beats first..11 of a 4x3 frame, data base+i; stall>=0 drops tready for 3 beats from there
  task automatic send_frame(input logic [7:0] base, input int first, input bit exp_on, input int stall);
    for (int i = first; i < 12; i++) begin
      if (exp_on && (stall < 0 || i < stall)) push(8'(int'(base) + i), (i % 4) == 3, i == 0);
      if (exp_on && i == stall) push(8'h00, 1'b1, 1'b0);
      drive(8'(int'(base) + i), (i % 4) == 3, i == 0, !(stall >= 0 && i >= stall && i < stall + 3));
    end
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d beats missing expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    s_aresetn = 1'b0;
    ctrl_cmd = 4'b0000;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnts", 32'({frame_cnt, drop_cnt, geom_err}), 0);
    s_aresetn = 1'b1;
    // two back-to-back frames in run mode
    cmd(4'b0001);
    idle(2);
    send_frame(8'h10, 0, 1, -1);
    send_frame(8'h20, 0, 1, -1);
    idle(1);
    drain("run2");
    chk("run2_frame_cnt", 32'(frame_cnt), 2);
    chk("run2_busy", 32'(busy), 0);
    // run started mid-frame: tail discarded, next frame passes
    cmd(4'b0000);
    idle(2);
    cmd(4'b0001);
    idle(2);
    send_frame(8'h30, 5, 0, -1);
    send_frame(8'h40, 0, 1, -1);
    idle(1);
    drain("midstart");
    chk("midstart_frame_cnt", 32'(frame_cnt), 3);
    // overflow at beat 5 (line 1): held beat 4, synthetic tlast, then the next frame intact
    send_frame(8'h50, 0, 1, 5);
    send_frame(8'h70, 0, 1, -1);
    idle(1);
    drain("overflow");
    chk("overflow_drop_cnt", 32'(drop_cnt), 1);
    chk("overflow_frame_cnt", 32'(frame_cnt), 4);
    chk("overflow_geom", 32'(geom_err), 0);
    // single shot with three frames streaming
    cmd(4'b0000);
    idle(3);
    cmd(4'b0010);
    idle(2);
    send_frame(8'h80, 0, 1, -1);
    send_frame(8'h90, 0, 0, -1);
    send_frame(8'hA0, 0, 0, -1);
    idle(2);
    drain("single");
    chk("single_frame_cnt", 32'(frame_cnt), 5);
    chk("single_busy", 32'(busy), 0);
    chk("single_tvalid", 32'(m_axis_tvalid), 0);
    // short line then SOF at (1,1): restart frame, all beats forwarded
    cmd(4'b0001);
    idle(2);
    push(8'h60, 1'b0, 1'b1); drive(8'h60, 1'b0, 1'b1, 1'b1);
    push(8'h61, 1'b0, 1'b0); drive(8'h61, 1'b0, 1'b0, 1'b1);
    push(8'h62, 1'b1, 1'b0); drive(8'h62, 1'b1, 1'b0, 1'b1);
    push(8'h63, 1'b0, 1'b0); drive(8'h63, 1'b0, 1'b0, 1'b1);
    push(8'h64, 1'b0, 1'b1); drive(8'h64, 1'b0, 1'b1, 1'b1);
    send_frame(8'h64, 1, 1, -1);
    idle(1);
    drain("geom");
    chk("geom_err", 32'(geom_err), 1);
    chk("geom_frame_cnt", 32'(frame_cnt), 6);
    cmd(4'b0011);
    cmd(4'b0001);
    chk("clr_geom", 32'(geom_err), 0);
    chk("clr_frame_cnt", 32'(frame_cnt), 0);
    chk("clr_drop_cnt", 32'(drop_cnt), 0);
    // one frame, then reset in the middle of line 1
    idle(1);
    send_frame(8'hB0, 0, 1, -1);
    idle(1);
    drain("prereset");
    chk("prereset_frame_cnt", 32'(frame_cnt), 1);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push(8'(8'hC0 + i), (i % 4) == 3, i == 0);
      drive(8'(8'hC0 + i), (i % 4) == 3, i == 0, 1'b1);
    end
    @(posedge clk);
    #1;
    chk("prereset_busy", 32'(busy), 1);
    s_aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(m_axis_tvalid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cnts", 32'({frame_cnt, drop_cnt, geom_err}), 0);
    drain("reset");
    s_aresetn = 1'b1;
    idle(2);
    chk("post_tvalid", 32'(m_axis_tvalid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
